// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: a - b processed LSB-first through one
// full-subtractor cell with a registered borrow, valid/ready on both sides.
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out,
   output logic             zero,
   output logic             busy
);

   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_sr_q, a_sr_d;
   logic [WIDTH-1:0] b_sr_q, b_sr_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             borrow_q, borrow_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             x, y, w;

   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
      state_d  = state_q;
      a_sr_d   = a_sr_q;
      b_sr_d   = b_sr_q;
      diff_d   = diff_q;
      borrow_d = borrow_q;
      cnt_d    = cnt_q;
      x        = a_sr_q[0];
      y        = b_sr_q[0];
      w        = borrow_q;

      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               a_sr_d   = a;
               b_sr_d   = b;
               diff_d   = '0;
               borrow_d = 1'b0;
               cnt_d    = '0;
               state_d  = S_RUN;
            end
         end
         S_RUN: begin
            diff_d   = {x ^ y ^ w, diff_q[WIDTH-1:1]};
            borrow_d = (~x & y) | (~(x ^ y) & w);
            a_sr_d   = a_sr_q >> 1;
            b_sr_d   = b_sr_q >> 1;
            cnt_d    = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_BIT) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together on the edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         a_sr_q   <= '0;
         b_sr_q   <= '0;
         diff_q   <= '0;
         borrow_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         a_sr_q   <= a_sr_d;
         b_sr_q   <= b_sr_d;
         diff_q   <= diff_d;
         borrow_q <= borrow_d;
         cnt_q    <= cnt_d;
      end
   end

   // Outputs decode registered state only; zero is qualified so it reads 0 outside DONE.
   assign in_ready   = (state_q == S_IDLE);
   assign busy       = (state_q == S_RUN);
   assign out_valid  = (state_q == S_DONE);
   assign diff       = diff_q;
   assign borrow_out = borrow_q;
   assign zero       = out_valid && (diff_q == '0);

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial unsigned subtractor computing `a - b` LSB-first, one bit per clock, through a single full-subtractor cell with a registered borrow. It is the subtracting counterpart of the team's full-adder cell and trades latency for area. Operands arrive and results leave over valid/ready handshakes, so it drops into the same datapaths as the serial adder stages.

## Interface
Parameters:
- `WIDTH`, default 8: operand and result width in bits; legal range WIDTH >= 2.

Ports:
- `clk`, input, 1: the single clock; all state changes on its rising edge.
- `rst`, input, 1: reset, asynchronous and active-high.
- `in_valid`, input, 1: operands `a`/`b` are valid.
- `in_ready`, output, 1: block can accept operands.
- `a`, input, WIDTH: minuend.
- `b`, input, WIDTH: subtrahend.
- `out_valid`, output, 1: result is valid.
- `out_ready`, input, 1: consumer accepts result.
- `diff`, output, WIDTH: `(a - b) mod 2^WIDTH`.
- `borrow_out`, output, 1: final borrow; 1 iff `a < b` (unsigned).
- `zero`, output, 1: 1 iff `diff == 0`.
- `busy`, output, 1: state is RUN.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - `in_ready = 1`.
  - On `in_valid & in_ready`: capture `a` and `b` into shift registers, clear the borrow register and the bit counter, go to RUN.
- RUN, once per cycle:
  - Take `x = a_sr[0]`, `y = b_sr[0]`, `w = borrow`.
  - Compute `d = x^y^w` and `borrow' = (~x & y) | (~(x^y) & w)`.
  - Shift `a_sr` and `b_sr` right by one. Shift `d` into the MSB of the diff register (right shift).
  - Increment the counter. On the WIDTH-th bit, go to DONE.
- DONE:
  - `out_valid = 1`; `diff`, `borrow_out` and `zero` are held stable.
  - On `out_valid & out_ready`, go to IDLE.
- `in_ready` is 1 only in IDLE. `in_valid` in RUN or DONE is ignored and operands are not sampled.
- Operands are captured at the accept edge, so `a`/`b` may change afterwards without effect.
- `zero` is derived from the diff register and is meaningful only while `out_valid = 1`.
- Counter width is `$clog2(WIDTH+1)`. The counter does not wrap within an operation.
- The modular result wraps: `0 - 1` gives all-ones with `borrow_out = 1`.

## Timing
- Reset (async assert, synchronous-edge release):
  - State goes to IDLE immediately.
  - `in_ready = 1`; `out_valid`, `busy`, `diff`, `borrow_out` and `zero` are all 0.
  - Internal shift registers, counter and borrow are cleared.
- Reset mid-RUN or mid-DONE aborts the operation. No result is emitted and the block returns to the reset values above.
- The accept edge is edge 0; `busy = 1` from edge 0 through edge WIDTH.
- Bits are processed on edges 1..WIDTH; `out_valid` rises after edge WIDTH. Latency is WIDTH cycles from accept to `out_valid`.
- `out_valid` stays high until the handshake edge and falls after it; `in_ready` rises after that same edge.
- Minimum initiation interval is WIDTH+2 cycles, with `out_ready` tied high and `in_valid` held high.
- No combinational path from any input to any output. `in_ready` and `busy` decode registered state only.

## Test plan
- WIDTH=8, `a=0x5A`, `b=0x23`, `out_ready=1` -> `out_valid` 8 cycles after accept, `diff=0x37`, `borrow_out=0`, `zero=0`.
- `a=0x00`, `b=0x01` -> `diff=0xFF`, `borrow_out=1`; then `a=0x80`, `b=0x80` -> `diff=0x00`, `zero=1`, `borrow_out=0`.
- Backpressure, `a=0x10`, `b=0x03`, `out_ready=0` for 5 cycles after `out_valid` -> `diff=0x0D` held stable with `out_valid=1` throughout, `in_ready=0`; IDLE one cycle after `out_ready` rises.
- `in_valid` held with new operands (`0xFF`, `0x01`) during RUN and DONE of a prior op -> ignored. Second op is accepted only after return to IDLE and yields `0xFE`.
- Assert `rst` at cycle 3 of RUN -> immediately `busy=0`, `out_valid=0`, `in_ready=1`, `diff=0`. No result is emitted. A following op `0x09-0x04` returns `0x05`.
- Back-to-back with `in_valid=1`, `out_ready=1` -> accepts exactly every 10 cycles (WIDTH+2); 256 random pairs match the `(a-b) mod 256` / `a<b` model.
